// File: rtl/mfu_pkg.sv
// ---------------------------------------------------------------------------
// mfu_pkg : shared types, precision/sign-select codes and brick-count helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] PREC2 = 2'b00;
    localparam logic [1:0] PREC4 = 2'b01;
    localparam logic [1:0] PREC8 = 2'b10;

    // Sign select is {a_brick_signed, b_brick_signed}
    localparam logic [1:0] SEL_UU = 2'b00;
    localparam logic [1:0] SEL_US = 2'b01;
    localparam logic [1:0] SEL_SU = 2'b10;
    localparam logic [1:0] SEL_SS = 2'b11;

    function automatic int brick_count(input logic [1:0] prec, input int dw);
        int p;
        p = 2 << prec;
        if (p > dw) begin
            p = dw;
        end
        return p / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfu_bitbrick_mac_bb2x2_mul.sv
// ---------------------------------------------------------------------------
// bb2x2_mul : combinational 2x2 bit-brick multiplier with per-operand signedness
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bb2x2_mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] prod
);

    logic signed [3:0] a_ext;
    logic signed [3:0] b_ext;

    // Every signed/unsigned 2x2 product fits the low 4 bits exactly
    always_comb begin
        a_ext = $signed({{2{sel[1] & a[1]}}, a});
        b_ext = $signed({{2{sel[0] & b[1]}}, b});
        prod  = a_ext * b_ext;
    end

endmodule

`default_nettype wire

// File: rtl/mfu_bitbrick_mac.sv
// ---------------------------------------------------------------------------
// mfu_bitbrick_mac : sequential precision-scalable MAC, one 2x2 brick per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mfu_bitbrick_mac
    import mfu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          a_signed,
    input  logic          b_signed,
    input  logic [1:0]    prec,
    input  logic          acc_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] result,
    output logic          busy
);

    localparam int NW = $clog2(DW / 2 + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic            a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d;
    logic [NW-1:0]   n_q, n_d, i_q, i_d, j_q, j_d;
    logic [AW-1:0]   acc_q, acc_d, result_q, result_d;
    logic            out_valid_q, out_valid_d;

    logic [NW-1:0]   n_last;
    logic [1:0]      a_brick, b_brick, sel;
    logic [3:0]      prod;
    logic [AW-1:0]   pp_ext, pp;
    logic [NW+1:0]   shamt;

    bb2x2_mul u_brick (
        .a    (a_brick),
        .b    (b_brick),
        .sel  (sel),
        .prod (prod)
    );

    // Only the top brick of a signed operand carries the sign
    always_comb begin
        n_last  = n_q - 1'b1;
        a_brick = a_q[{i_q, 1'b0} +: 2];
        b_brick = b_q[{j_q, 1'b0} +: 2];
        sel     = {a_sgn_q & (i_q == n_last), b_sgn_q & (j_q == n_last)};
        pp_ext  = (sel == SEL_UU) ? {{(AW-4){1'b0}}, prod} : {{(AW-4){prod[3]}}, prod};
        shamt   = ({2'b00, i_q} + {2'b00, j_q}) << 1;
        pp      = pp_ext << shamt;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        a_sgn_d     = a_sgn_q;
        b_sgn_d     = b_sgn_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    a_sgn_d = a_signed;
                    b_sgn_d = b_signed;
                    n_d     = NW'(brick_count(prec, DW));
                    i_d     = '0;
                    j_d     = '0;
                    if (acc_clr) begin
                        acc_d = '0;
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + pp;
                if (j_q == n_last) begin
                    j_d = '0;
                    if (i_q == n_last) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DONE: begin
                // First DONE cycle registers the final sum; the handshake follows
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    result_d    = acc_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            a_sgn_q     <= 1'b0;
            b_sgn_q     <= 1'b0;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_sgn_q     <= a_sgn_d;
            b_sgn_q     <= b_sgn_d;
            n_q         <= n_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mfu_bitbrick_mac.sv
// ---------------------------------------------------------------------------
// tb_mfu_bitbrick_mac : directed + randomized bench against an arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mfu_bitbrick_mac;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam longint MASK = (64'sd1 <<< AW) - 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          a_signed = 1'b0;
    logic          b_signed = 1'b0;
    logic [1:0]    prec = 2'b00;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] result;
    logic          busy;

    int     n_cmp = 0;
    int     n_err = 0;
    longint acc_m = 0;

    mfu_bitbrick_mac #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .prec      (prec),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_p(input logic [1:0] pc);
        int p;
        p = 2 << pc;
        return (p > DW) ? DW : p;
    endfunction

    function automatic longint opval(input logic [DW-1:0] d, input bit s, input int p);
        longint v;
        v = longint'(d) & ((64'sd1 <<< p) - 1);
        if (s && v[p-1]) begin
            v = v - (64'sd1 <<< p);
        end
        return v;
    endfunction

    task automatic run_txn(input logic [DW-1:0] ta, input logic [DW-1:0] tbv, input bit as,
                           input bit bs, input logic [1:0] tp, input bit clr, input int hold);
        int p, n, cyc;
        logic [AW-1:0] exp;
        p = eff_p(tp);
        n = p / 2;
        if (clr) acc_m = 0;
        acc_m = (acc_m + opval(ta, as, p) * opval(tbv, bs, p)) & MASK;
        exp = acc_m[AW-1:0];
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a = ta; b = tbv; a_signed = as; b_signed = bs; prec = tp; acc_clr = clr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            check("in_ready_run", {63'd0, in_ready}, 64'd0);
            in_valid = 1'($urandom);
            a = DW'($urandom); b = DW'($urandom); acc_clr = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(n * n + 1));
        check("result", 64'(result), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", 64'(result), 64'(exp));
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", {63'd0, out_valid}, 64'd0);
        check("post_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_busy", {63'd0, busy}, 64'd0);
        check("post_result", 64'(result), 64'(exp));
    endtask

    initial begin
        #2;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        #10 nrst = 1'b1;
        @(posedge clk); #1;

        run_txn(8'h03, 8'h03, 0, 0, 2'b00, 1, 0);
        check("plan1", 64'(result), 64'd9);
        run_txn(8'h0F, 8'h08, 0, 1, 2'b01, 1, 1);
        check("plan2", 64'(result), 64'hFFFF88);
        run_txn(8'h80, 8'h80, 1, 1, 2'b10, 1, 0);
        check("plan3_ss", 64'(result), 64'd16384);
        run_txn(8'h80, 8'h80, 0, 0, 2'b10, 1, 0);
        check("plan3_uu", 64'(result), 64'd16384);
        run_txn(8'h80, 8'h80, 1, 0, 2'b10, 1, 0);
        check("plan3_su", 64'(result), 64'hFFC000);
        run_txn(8'd5, 8'd7, 0, 0, 2'b10, 1, 0);
        check("plan4_a", 64'(result), 64'd35);
        run_txn(8'hFD, 8'h04, 1, 1, 2'b10, 0, 0);
        check("plan4_b", 64'(result), 64'd23);
        run_txn(8'd2, 8'd2, 0, 0, 2'b10, 1, 0);
        check("plan4_c", 64'(result), 64'd4);
        run_txn(8'h81, 8'h7F, 1, 0, 2'b11, 1, 5);

        // Reset during RUN cycle 7 of an 8-bit job
        a = 8'h55; b = 8'hAA; a_signed = 1'b0; b_signed = 1'b1; prec = 2'b10; acc_clr = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        acc_m = 0;
        #2 nrst = 1'b1;
        @(posedge clk); #1;
        run_txn(8'h03, 8'h03, 0, 0, 2'b01, 0, 0);
        check("arst_new_job", 64'(result), 64'd9);

        for (int t = 0; t < 40; t++) begin
            run_txn(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
